psr_flag_unit: RTL and testbench
================================

// Module: psr_flag_unit
// PURPOSE
//  Producer side of the branch-condition interface: computes C/F/L/Z/N from executed ALU ops and holds them in the
//  architectural PSR. The registered psr output feeds the branch condition checker; the combinational psr_fwd feeds
//  a compare immediately followed by a branch. Also handles explicit PSR load and interrupt save/restore.
// PARAMETERS
//  WIDTH       16       ALU operand width in bits
//  PSR_RST     5'b00000 reset/clear value of psr
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_n      in   1      asynchronous reset, active low
//  alu_valid    in   1      an ALU op completes this cycle
//  alu_op       in   2      00 NONE, 01 ADD, 10 SUB, 11 CMP
//  op_a         in   WIDTH  Rdest operand
//  op_b         in   WIDTH  Rsrc operand
//  stall        in   1      pipeline hold; blocks all psr/shadow updates
//  psr_wr       in   1      explicit load of psr from psr_wdata (LPR)
//  psr_wdata    in   5      value for psr_wr
//  save_req     in   1      interrupt entry: copy psr to shadow
//  restore_req  in   1      interrupt return: copy shadow to psr
//  psr          out  5      registered PSR {N,Z,L,C,F} = bits [4:0]
//  psr_fwd      out  5      next-state PSR (combinational bypass)
//  conflict     out  1      registered 1-cycle pulse: a lower-priority update was dropped
// BEHAVIOUR
//  - Bit map is fixed: [4]=N, [3]=Z, [2]=L, [1]=C, [0]=F. Consumers index only by these positions.
//  - Reset (async, reset_n=0): psr=PSR_RST, shadow=PSR_RST, conflict=0. psr_fwd=PSR_RST while in reset.
//  - Latency: flags from an op with alu_valid=1 at edge k appear on psr after edge k; psr_fwd shows them in cycle k.
//  - ADD: sum=op_a+op_b on WIDTH+1 bits. C=sum[WIDTH]. F=signed overflow (operand signs equal, result sign differs).
//    ADD writes only C and F; N, Z and L hold.
//  - SUB: diff=op_a-op_b. C=borrow (op_a<op_b unsigned). F=signed overflow of the subtraction.
//    SUB writes only C and F; N, Z and L hold.
//  - CMP: Z=(op_a==op_b). L=(op_a>op_b) unsigned. N=(op_a>op_b) signed. CMP writes only Z, L and N; C and F hold.
//  - NONE with alu_valid=1: no flag change.
//  - Per-cycle priority when stall=0: restore_req > psr_wr > alu update > hold. Only one source writes psr.
//  - conflict is 1 the cycle after any dropped source: restore with psr_wr, restore with a valid op, or psr_wr with
//    a valid op (op != NONE).
//  - save_req with any psr update in the same cycle: shadow captures the old psr and the update still applies.
//  - save_req with restore_req: psr<=shadow and shadow<=old psr (swap).
//  - stall=1: psr, shadow and conflict (forced 0) hold; all requests are ignored, not queued. psr_fwd=psr.
//  - Extreme values: CMP 0x8000 vs 0x7FFF gives N=0, L=1, Z=0. ADD 0xFFFF+0x0001 gives C=1, F=0.
//  - Reset mid-operation: all state clears immediately; no pending update survives.
// CONFIGURATION
//  PSR_SHADOW_EN defined: 1-deep shadow register; save_req and restore_req behave as above.
//  PSR_SHADOW_EN undefined: no shadow flop. save_req and restore_req are ignored, and restore never causes
//    a conflict. Ports stay present so the interface is unchanged.
// STRUCTURE
//  psr_pkg: bit-index localparams (PSR_N..PSR_F), alu_op encodings, per-op update masks
//    (ADD/SUB=5'b00011, CMP=5'b11100), PSR_RST default.
//  Sub-module psr_flag_calc (combinational): op_a, op_b, alu_op -> flags[4:0] and mask[4:0].
//    The top level merges as psr_next = (psr & ~mask) | (flags & mask) and adds priority, shadow and conflict logic.
// TESTING
//  1. reset_n=0 mid-stream with psr=5'b11111 -> psr=0 asynchronously, conflict=0, shadow=0.
//  2. CMP a=5,b=3 -> psr_fwd=5'b10100 same cycle, psr=5'b10100 next; then CMP 3,3 -> Z=1, L=0, N=0; C/F unchanged.
//  3. ADD 0x7FFF+1 -> F=1, C=0; ADD 0xFFFF+1 -> C=1, F=0; N/Z/L unchanged in both.
//  4. SUB 2-5 -> C=1; SUB 0x8000-1 -> F=1. CMP 0x8000 vs 0x7FFF -> N=0, L=1.
//  5. psr_wr=1 wdata=5'b01010 with CMP valid -> psr=5'b01010, conflict=1 next cycle; stall=1 with CMP -> psr holds.
//  6. (PSR_SHADOW_EN) psr=5'b01000, save_req, then CMP 9,1 (N=1, L=1), then restore_req -> psr=5'b01000.
//     Without the macro the same sequence leaves psr=5'b10100.

Source files
------------

// File: rtl/psr_pkg.sv
// Shared definitions for the PSR flag unit: bit positions, ALU op encodings and per-op update masks.
// The optional shadow register is enabled by defining PSR_SHADOW_EN when building psr_flag_unit.
package psr_pkg;

    localparam int PSR_W = 5;

    // Consumers index the PSR only by these positions.
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_L = 2;
    localparam int PSR_C = 1;
    localparam int PSR_F = 0;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CMP  = 2'b11
    } alu_op_e;

    localparam logic [PSR_W-1:0] MASK_NONE  = 5'b00000;
    localparam logic [PSR_W-1:0] MASK_ARITH = 5'b00011;
    localparam logic [PSR_W-1:0] MASK_CMP   = 5'b11100;

    localparam logic [PSR_W-1:0] PSR_RST_DEFAULT = 5'b00000;

    function automatic logic [PSR_W-1:0] psr_merge(
        input logic [PSR_W-1:0] old_psr,
        input logic [PSR_W-1:0] flags,
        input logic [PSR_W-1:0] mask
    );
        return (old_psr & ~mask) | (flags & mask);
    endfunction

endpackage

// File: rtl/psr_flag_calc.sv
// Combinational flag generator: derives candidate flags and the mask of PSR bits the op is allowed to write.
module psr_flag_calc
    import psr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       alu_op,
    output logic [PSR_W-1:0] flags,
    output logic [PSR_W-1:0] mask
);

    logic        [WIDTH:0]   sum;
    logic        [WIDTH:0]   diff;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    sign_a;
    logic                    sign_b;

    assign sum    = {1'b0, op_a} + {1'b0, op_b};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign diff   = {1'b0, op_a} - {1'b0, op_b};
    assign sa     = op_a;
    assign sb     = op_b;
    assign sign_a = op_a[WIDTH-1];
    assign sign_b = op_b[WIDTH-1];

    always_comb begin
        flags = '0;
        mask  = MASK_NONE;
        unique case (alu_op_e'(alu_op))
            OP_ADD: begin
                flags[PSR_C] = sum[WIDTH];
                flags[PSR_F] = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
                mask         = MASK_ARITH;
            end
            OP_SUB: begin
                flags[PSR_C] = diff[WIDTH];
                flags[PSR_F] = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
                mask         = MASK_ARITH;
            end
            OP_CMP: begin
                flags[PSR_Z] = (op_a == op_b);
                flags[PSR_L] = (op_a > op_b);
                flags[PSR_N] = (sa > sb);
                mask         = MASK_CMP;
            end
            default: begin
                flags = '0;
                mask  = MASK_NONE;
            end
        endcase
    end

endmodule

// File: rtl/psr_flag_unit.sv
// Architectural PSR with combinational bypass, explicit load, priority arbitration and optional
// interrupt shadow register (enabled by defining PSR_SHADOW_EN).
module psr_flag_unit
    import psr_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [PSR_W-1:0] PSR_RST = PSR_RST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_valid,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             stall,
    input  logic             psr_wr,
    input  logic [PSR_W-1:0] psr_wdata,
    input  logic             save_req,
    input  logic             restore_req,
    output logic [PSR_W-1:0] psr,
    output logic [PSR_W-1:0] psr_fwd,
    output logic             conflict
);

    logic [PSR_W-1:0] psr_q;
    logic [PSR_W-1:0] psr_d;
    logic [PSR_W-1:0] shadow_q;
    logic             conflict_q;
    logic             conflict_d;

    logic [PSR_W-1:0] calc_flags;
    logic [PSR_W-1:0] calc_mask;
    logic [PSR_W-1:0] alu_psr;
    logic             op_valid;
    logic             restore_en;
    logic             save_en;

    psr_flag_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_op (alu_op),
        .flags  (calc_flags),
        .mask   (calc_mask)
    );

    assign op_valid = alu_valid && (alu_op != OP_NONE);
    assign alu_psr  = psr_merge(psr_q, calc_flags, alu_valid ? calc_mask : MASK_NONE);

`ifdef PSR_SHADOW_EN
    logic [PSR_W-1:0] shadow_d;

    assign restore_en = restore_req;
    assign save_en    = save_req;
    // Save always captures the pre-update PSR, which also yields the swap on save+restore.
    assign shadow_d   = (!stall && save_en) ? psr_q : shadow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= PSR_RST;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_shadow_reqs;

    assign restore_en         = 1'b0;
    assign save_en            = 1'b0;
    assign shadow_q           = PSR_RST;
    assign unused_shadow_reqs = save_req ^ restore_req ^ save_en;
`endif

    always_comb begin
        psr_d      = psr_q;
        conflict_d = 1'b0;
        if (!stall) begin
            if (restore_en) begin
                psr_d = shadow_q;
            end else if (psr_wr) begin
                psr_d = psr_wdata;
            end else begin
                psr_d = alu_psr;
            end
            conflict_d = (restore_en && (psr_wr || op_valid)) || (psr_wr && op_valid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q      <= PSR_RST;
            conflict_q <= 1'b0;
        end else begin
            psr_q      <= psr_d;
            conflict_q <= conflict_d;
        end
    end

    assign psr      = psr_q;
    assign conflict = conflict_q;
    // Bypass is forced to the reset value while reset is held so consumers never see stale flags.
    assign psr_fwd  = reset_n ? psr_d : PSR_RST;

endmodule

// File: tb/tb_psr_flag_unit.sv
// Self-checking bench for psr_flag_unit: directed scenarios plus randomized traffic against an arithmetic model.
module tb_psr_flag_unit;

`ifdef PSR_SHADOW_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [1:0]  alu_op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        stall;
    logic        psr_wr;
    logic [4:0]  psr_wdata;
    logic        save_req;
    logic        restore_req;
    logic [4:0]  psr;
    logic [4:0]  psr_fwd;
    logic        conflict;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] m_psr;
    logic [4:0] m_sh;
    logic       m_conf;

    psr_flag_unit #(
        .WIDTH   (16),
        .PSR_RST (5'b00000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .psr_wr      (psr_wr),
        .psr_wdata   (psr_wdata),
        .save_req    (save_req),
        .restore_req (restore_req),
        .psr         (psr),
        .psr_fwd     (psr_fwd),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flags from plain integer arithmetic: carry/borrow and signed-range overflow.
    function automatic logic [4:0] ref_alu(input logic [4:0] p, input logic [1:0] op,
                                           input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r;
        logic [4:0] q;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        q = p;
        case (op)
            2'd1: begin
                q[1] = (ua + ub) > 65535;
                r    = sa + sb;
                q[0] = (r > 32767) || (r < -32768);
            end
            2'd2: begin
                q[1] = ua < ub;
                r    = sa - sb;
                q[0] = (r > 32767) || (r < -32768);
            end
            2'd3: begin
                q[3] = ua == ub;
                q[2] = ua > ub;
                q[4] = sa > sb;
            end
            default: q = p;
        endcase
        return q;
    endfunction

    task automatic set_idle();
        alu_valid = 0; alu_op = 0; op_a = 0; op_b = 0; stall = 0;
        psr_wr = 0; psr_wdata = 0; save_req = 0; restore_req = 0;
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic st, input logic wr, input logic [4:0] wd,
                        input logic sv, input logic rs);
        logic [4:0] nxt, shn;
        logic cf, opv, rse, sve;
        @(negedge clk);
        check_eq("psr", psr, m_psr);
        check_eq("conflict", conflict, m_conf);
        alu_valid = v; alu_op = op; op_a = a; op_b = b; stall = st;
        psr_wr = wr; psr_wdata = wd; save_req = sv; restore_req = rs;
        #1;
        opv = v && (op != 2'd0);
        rse = SH_EN && rs;
        sve = SH_EN && sv;
        if (st) begin
            nxt = m_psr; shn = m_sh; cf = 0;
        end else begin
            if (rse)      nxt = m_sh;
            else if (wr)  nxt = wd;
            else if (v)   nxt = ref_alu(m_psr, op, a, b);
            else          nxt = m_psr;
            shn = sve ? m_psr : m_sh;
            cf  = (rse && (wr || opv)) || (wr && opv);
        end
        check_eq("psr_fwd", psr_fwd, nxt);
        @(posedge clk);
        #1;
        m_psr = nxt; m_sh = shn; m_conf = cf;
        set_idle();
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            5: return 16'($urandom_range(0, 3));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        set_idle();
        reset_n = 0;
        m_psr = 0; m_sh = 0; m_conf = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_psr", psr, 5'b00000);
        check_eq("rst_conflict", conflict, 0);
        check_eq("rst_fwd", psr_fwd, 5'b00000);
        @(negedge clk);
        reset_n = 1;

        // CMP forwarding and registered result
        step(1, 2'd3, 16'd5, 16'd3, 0, 0, 0, 0, 0);
        check_eq("cmp53", psr, 5'b10100);
        step(1, 2'd3, 16'd3, 16'd3, 0, 0, 0, 0, 0);
        check_eq("cmp33", psr, 5'b01000);
        // ADD / SUB / CMP extremes
        step(1, 2'd1, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 0);
        check_eq("add_ovf", psr, 5'b01001);
        step(1, 2'd1, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0);
        check_eq("add_carry", psr, 5'b01010);
        step(1, 2'd2, 16'd2, 16'd5, 0, 0, 0, 0, 0);
        check_eq("sub_borrow", psr, 5'b01010);
        step(1, 2'd2, 16'h8000, 16'h0001, 0, 0, 0, 0, 0);
        check_eq("sub_ovf", psr, 5'b01001);
        step(1, 2'd3, 16'h8000, 16'h7FFF, 0, 0, 0, 0, 0);
        check_eq("cmp_ext", psr, 5'b00101);
        // NONE with valid changes nothing
        step(1, 2'd0, 16'h1234, 16'h1234, 0, 0, 0, 0, 0);
        check_eq("none", psr, 5'b00101);
        // psr_wr beats a valid CMP; then stall blocks everything
        step(1, 2'd3, 16'd5, 16'd3, 0, 1, 5'b01010, 0, 0);
        check_eq("wr_prio", psr, 5'b01010);
        check_eq("wr_conflict", conflict, 1);
        step(1, 2'd3, 16'd5, 16'd3, 1, 1, 5'b11111, 1, 1);
        check_eq("stall_psr", psr, 5'b01010);
        check_eq("stall_conflict", conflict, 0);
        // Shadow save / restore
        step(0, 2'd0, 0, 0, 0, 1, 5'b01000, 0, 0);
        step(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 2'd3, 16'd9, 16'd1, 0, 0, 0, 0, 0);
        check_eq("sh_cmp91", psr, 5'b10100);
        step(0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("sh_restore", psr, SH_EN ? 5'b01000 : 5'b10100);

        // Asynchronous reset mid-stream
        step(0, 2'd0, 0, 0, 0, 1, 5'b11111, 0, 0);
        step(1, 2'd3, 16'd1, 16'd2, 0, 1, 5'b11111, 1, 0);
        check_eq("pre_rst_psr", psr, 5'b11111);
        check_eq("pre_rst_conf", conflict, 1);
        #2;
        reset_n = 0;
        #1;
        check_eq("arst_psr", psr, 5'b00000);
        check_eq("arst_conflict", conflict, 0);
        alu_valid = 1; alu_op = 2'd3; op_a = 16'd9; op_b = 16'd1; psr_wr = 1; psr_wdata = 5'b11111;
        #1;
        check_eq("arst_fwd", psr_fwd, 5'b00000);
        @(posedge clk);
        #1;
        check_eq("arst_hold", psr, 5'b00000);
        set_idle();
        m_psr = 0; m_sh = 0; m_conf = 0;
        @(negedge clk);
        reset_n = 1;
        step(0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
        check_eq("arst_shadow", psr, 5'b00000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), pick_operand(), pick_operand(),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, 5'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        check_eq("final_psr", psr, m_psr);
        check_eq("final_conflict", conflict, m_conf);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
